ram_bist_ctrl: RTL and testbench
================================

Name: ram_bist_ctrl

Overview:
Initiator-side engine for the single-port `ram` (en/wr/addr/write/read interface). On `start` it writes a selectable data pattern to every address, then reads every address back. It compares each read against the expected pattern and reports pass/fail, an error count and the first failing address/data. It sits between the system and a `ram` instance: a power-on/self-test master that releases the RAM port when idle.

Parameters:
ADDR_W, 3, RAM address width; DEPTH = 2**ADDR_W
DATA_W, 8, RAM data width
RD_LAT, 1, edges from the RAM's read-sampling edge to the edge at which mem_rdata is captured (1 = registered read)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin test; sampled only in IDLE
pattern  in  2  0=address, 1=checkerboard, 2=inverted address, 3=all-ones; latched at start
busy  out  1  test in progress
done  out  1  sticky completion flag; cleared by next accepted start or rst
pass  out  1  done && err_cnt==0
err_cnt  out  ADDR_W+1  mismatching words, saturating at all-ones
fail_addr  out  ADDR_W  address of first mismatch
fail_data  out  DATA_W  data read at first mismatch
mem_en  out  1  RAM enable
mem_wr  out  1  RAM write(1)/read(0)
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data

Behaviour:
- All outputs registered. Reset values are all 0: busy, done, pass, err_cnt, fail_addr, fail_data, mem_en, mem_wr, mem_addr, mem_wdata.
- FSM states: IDLE, WRITE, READ, DRAIN, FIN.
- IDLE: mem_en=0. start=1 at edge E0 latches pattern, clears done/pass/err_cnt/fail_*, sets busy, and moves to WRITE.
- WRITE: mem_en=1, mem_wr=1. Address k=0..DEPTH-1 is driven in the cycle after edge E(k), with mem_wdata=pat(k). After k=DEPTH-1 the FSM goes to READ.
- READ: mem_en=1, mem_wr=0. Address j=0..DEPTH-1 is driven in the cycle after E(DEPTH+j). After j=DEPTH-1 the FSM goes to DRAIN.
- A delay line of depth RD_LAT+1 carries {valid, addr, expected}. At E(DEPTH+j+1+RD_LAT) mem_rdata is compared with pat(j).
- DRAIN: mem_en=0. Waits until the compare for j=DEPTH-1 completes, then goes to FIN.
- FIN: for one cycle, busy=0, done=1, pass=(err_cnt==0), then IDLE. done and pass hold until the next start or rst.
- DEPTH=8, RD_LAT=1: done is first high in the cycle after E18.
- Mismatch handling: err_cnt increments and saturates (no wrap). fail_addr/fail_data load only on the first mismatch, i.e. when err_cnt==0 before the increment.
- pat(a) by pattern:
  - 0: a zero-extended/truncated to DATA_W
  - 1: {DATA_W/2{2'b10}} for even a, {DATA_W/2{2'b01}} for odd a; for odd DATA_W the MSB is 0
  - 2: ~pat0(a)
  - 3: all-ones
- Boundary conditions:
  - start while busy: ignored.
  - start held high continuously: a new test starts in the IDLE cycle after FIN.
  - rst mid-test: all state returns to reset values at that edge; mem_en=0 in the following cycle; no partial result is reported.
  - rst and start in the same cycle: rst wins.
  - Address counter wraps DEPTH-1 -> 0 exactly at the WRITE->READ transition.
  - mem_wdata is don't-care outside WRITE; it is driven 0.

Decomposition:
- Package ram_bist_pkg holds:
  - the state enum {IDLE, WRITE, READ, DRAIN, FIN}
  - the pattern enum {PAT_ADDR, PAT_CHECKER, PAT_INV, PAT_ONES}
  - the constant for the checkerboard base word
- Sub-module ram_bist_pattern: a combinational pat(a) generator. It is instantiated once, shared by the write path and the expected-data path.

Test Plan:
1. Reset, then start with pattern=0, ADDR_W=3, DATA_W=8, good RAM -> RAM holds 0..7; done high after E18; pass=1; err_cnt=0.
2. pattern=1, good RAM -> writes 0xAA,0x55,0xAA,...; pass=1.
3. RAM model with bit0 stuck-at-0 at address 5, pattern=0 -> err_cnt=1; fail_addr=5; fail_data=0x04; pass=0.
4. RAM model with all bits stuck at 0, pattern=3 -> err_cnt=8; fail_addr=0; fail_data=0x00; err_cnt does not wrap.
5. Assert rst during READ at address 3 -> the next cycle has mem_en=0, busy=0, done=0. Then start with pattern=2 -> a normal full run; pass=1.
6. Pulse start during WRITE, and hold start high across FIN -> the mid-test pulse is ignored; a second test begins in the cycle after FIN returns to IDLE, and done clears on acceptance.

Source files
------------

// File: rtl/ram_bist_pkg.sv
// Shared types and constants for the RAM built-in self-test controller.
package ram_bist_pkg;

   typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, FIN} state_e;

   typedef enum logic [1:0] {PAT_ADDR, PAT_CHECKER, PAT_INV, PAT_ONES} pat_e;

   // Two-bit seed replicated across the word for the checkerboard pattern
   localparam logic [1:0] CHECKER_BASE = 2'b10;

endpackage

// File: rtl/ram_bist_ctrl_if.sv
// RAM port between the BIST controller (master) and a single-port RAM (slave).
interface ram_bist_ctrl_if #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
);
   logic              mem_en;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (output mem_en, mem_wr, mem_addr, mem_wdata, input mem_rdata);
   modport slave  (input mem_en, mem_wr, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/ram_bist_pattern.sv
// Combinational test-pattern generator: maps an address to its expected data word.
module ram_bist_pattern
   import ram_bist_pkg::*;
#(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
) (
   input  pat_e              i_sel,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] o_data
);
   logic [DATA_W+ADDR_W-1:0] w_ext;
   logic [DATA_W-1:0]        w_pat_addr;
   logic [DATA_W-1:0]        w_checker;

   assign w_ext      = {{DATA_W{1'b0}}, i_addr};
   assign w_pat_addr = w_ext[DATA_W-1:0];

   // Odd addresses flip the seed; an odd-width word leaves its MSB at 0
   always_comb begin
      w_checker = '0;
      for (int i = 0; i < 2 * (DATA_W / 2); i++) begin
         w_checker[i] = CHECKER_BASE[i[0]] ^ i_addr[0];
      end
   end

   always_comb begin
      o_data = '1;
      case (i_sel)
         PAT_ADDR:    o_data = w_pat_addr;
         PAT_CHECKER: o_data = w_checker;
         PAT_INV:     o_data = ~w_pat_addr;
         default:     o_data = '1;
      endcase
   end

endmodule

// File: rtl/ram_bist_ctrl.sv
// BIST master: writes a pattern to every RAM word, reads it back and reports mismatches.
module ram_bist_ctrl
   import ram_bist_pkg::*;
#(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        pattern,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W:0]   err_cnt,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_data,
   ram_bist_ctrl_if.master   mem
);
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
   localparam logic [ADDR_W:0]   ERR_MAX   = '1;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] exp;
   } dl_t;

   state_e            r_state, w_state_n;
   pat_e              r_pattern, w_pattern_n, w_pat_sel;
   logic [ADDR_W-1:0] r_addr, w_addr_n, w_addr_inc, w_pat_addr;
   logic [DATA_W-1:0] r_wdata, w_wdata_n, w_pat_data;
   logic              r_en, w_en_n, r_wr, w_wr_n;
   logic              r_busy, w_busy_n, r_done, w_done_n, r_pass, w_pass_n;
   logic [ADDR_W:0]   r_err_cnt, w_err_n;
   logic [ADDR_W-1:0] r_fail_addr, w_fail_addr_n;
   logic [DATA_W-1:0] r_fail_data, w_fail_data_n;
   dl_t               r_dl [RD_LAT+1];
   dl_t               w_push;
   logic              w_pending, w_mismatch;

   // One generator serves both the write data and the expected read data
   assign w_addr_inc = r_addr + 1'b1;
   assign w_pat_addr = (r_state == WRITE || r_state == READ) ? w_addr_inc : '0;
   assign w_pat_sel  = (r_state == IDLE) ? pat_e'(pattern) : r_pattern;

   ram_bist_pattern #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_pattern (
      .i_sel  (w_pat_sel),
      .i_addr (w_pat_addr),
      .o_data (w_pat_data)
   );

   always_comb begin
      w_pending = 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
         w_pending = w_pending | r_dl[i].valid;
      end
   end

   assign w_mismatch = r_dl[RD_LAT].valid && (mem.mem_rdata != r_dl[RD_LAT].exp);

   // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
   always_comb begin
      w_state_n     = r_state;
      w_pattern_n   = r_pattern;
      w_addr_n      = r_addr;
      w_en_n        = 1'b0;
      w_wr_n        = 1'b0;
      w_wdata_n     = '0;
      w_busy_n      = r_busy;
      w_done_n      = r_done;
      w_pass_n      = r_pass;
      w_err_n       = r_err_cnt;
      w_fail_addr_n = r_fail_addr;
      w_fail_data_n = r_fail_data;
      w_push        = '0;

      if (w_mismatch) begin
         if (r_err_cnt == '0) begin
            w_fail_addr_n = r_dl[RD_LAT].addr;
            w_fail_data_n = mem.mem_rdata;
         end
         if (r_err_cnt != ERR_MAX) w_err_n = r_err_cnt + 1'b1;
      end

      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_n     = WRITE;
               w_pattern_n   = pat_e'(pattern);
               w_busy_n      = 1'b1;
               w_done_n      = 1'b0;
               w_pass_n      = 1'b0;
               w_err_n       = '0;
               w_fail_addr_n = '0;
               w_fail_data_n = '0;
               w_en_n        = 1'b1;
               w_wr_n        = 1'b1;
               w_addr_n      = '0;
               w_wdata_n     = w_pat_data;
            end
         end
         WRITE: begin
            w_en_n   = 1'b1;
            w_addr_n = w_pat_addr;
            if (r_addr == LAST_ADDR) begin
               w_state_n    = READ;
               w_push.valid = 1'b1;
               w_push.addr  = w_pat_addr;
               w_push.exp   = w_pat_data;
            end else begin
               w_wr_n    = 1'b1;
               w_wdata_n = w_pat_data;
            end
         end
         READ: begin
            w_addr_n = w_pat_addr;
            if (r_addr == LAST_ADDR) begin
               w_state_n = DRAIN;
            end else begin
               w_en_n       = 1'b1;
               w_push.valid = 1'b1;
               w_push.addr  = w_pat_addr;
               w_push.exp   = w_pat_data;
            end
         end
         DRAIN: begin
            if (!w_pending) w_state_n = FIN;
         end
         FIN: begin
            w_state_n = IDLE;
            w_busy_n  = 1'b0;
            w_done_n  = 1'b1;
            w_pass_n  = (r_err_cnt == '0);
         end
         default: w_state_n = IDLE;
      endcase
   end

   // NOTE: the small read delay line is reset too, so a stale compare never survives rst.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_pattern   <= PAT_ADDR;
         r_addr      <= '0;
         r_en        <= 1'b0;
         r_wr        <= 1'b0;
         r_wdata     <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_err_cnt   <= '0;
         r_fail_addr <= '0;
         r_fail_data <= '0;
         for (int i = 0; i <= RD_LAT; i++) r_dl[i] <= '0;
      end else begin
         r_state     <= w_state_n;
         r_pattern   <= w_pattern_n;
         r_addr      <= w_addr_n;
         r_en        <= w_en_n;
         r_wr        <= w_wr_n;
         r_wdata     <= w_wdata_n;
         r_busy      <= w_busy_n;
         r_done      <= w_done_n;
         r_pass      <= w_pass_n;
         r_err_cnt   <= w_err_n;
         r_fail_addr <= w_fail_addr_n;
         r_fail_data <= w_fail_data_n;
         r_dl[0]     <= w_push;
         for (int i = 1; i <= RD_LAT; i++) r_dl[i] <= r_dl[i-1];
      end
   end

   assign busy          = r_busy;
   assign done          = r_done;
   assign pass          = r_pass;
   assign err_cnt       = r_err_cnt;
   assign fail_addr     = r_fail_addr;
   assign fail_data     = r_fail_data;
   assign mem.mem_en    = r_en;
   assign mem.mem_wr    = r_wr;
   assign mem.mem_addr  = r_addr;
   assign mem.mem_wdata = r_wdata;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl with a registered-read RAM model and injectable faults.
module tb_ram_bist_ctrl;
   localparam int ADDR_W = 3;
   localparam int DATA_W = 8;
   localparam int RD_LAT = 1;
   localparam int DEPTH  = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [1:0]        pattern;
   logic              busy, done, pass;
   logic [ADDR_W:0]   err_cnt;
   logic [ADDR_W-1:0] fail_addr;
   logic [DATA_W-1:0] fail_data;

   int n_checks = 0;
   int n_errors = 0;
   int fault_mode = 0;

   logic [DATA_W-1:0] ram_q [DEPTH];

   ram_bist_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ram_if ();

   ram_bist_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .pattern   (pattern),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_cnt   (err_cnt),
      .fail_addr (fail_addr),
      .fail_data (fail_data),
      .mem       (ram_if.master)
   );

   always #5 clk = ~clk;

   // Fault 1: bit0 stuck-at-0 at address 5; fault 2: every bit stuck-at-0
   function automatic logic [DATA_W-1:0] faulty(input logic [ADDR_W-1:0] a,
                                                input logic [DATA_W-1:0] d);
      case (fault_mode)
         1:       return (a == 3'd5) ? (d & 8'hFE) : d;
         2:       return 8'h00;
         default: return d;
      endcase
   endfunction

   always @(posedge clk) begin
      if (ram_if.mem_en && ram_if.mem_wr) ram_q[ram_if.mem_addr] <= ram_if.mem_wdata;
      if (ram_if.mem_en && !ram_if.mem_wr)
         ram_if.mem_rdata <= faulty(ram_if.mem_addr, ram_q[ram_if.mem_addr]);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Leaves the bench at #1 after E0
   task automatic start_test(input logic [1:0] p);
      pattern = p;
      start   = 1'b1;
      tick(1);
      start   = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; pattern = 2'd0; fault_mode = 0;
      ram_if.mem_rdata = '0;
      tick(2);
      rst = 1'b0;
      check("rst_busy",      32'(busy),             0);
      check("rst_done",      32'(done),             0);
      check("rst_pass",      32'(pass),             0);
      check("rst_err_cnt",   32'(err_cnt),          0);
      check("rst_fail_addr", 32'(fail_addr),        0);
      check("rst_fail_data", 32'(fail_data),        0);
      check("rst_mem_en",    32'(ram_if.mem_en),    0);
      check("rst_mem_wr",    32'(ram_if.mem_wr),    0);
      check("rst_mem_addr",  32'(ram_if.mem_addr),  0);
      check("rst_mem_wdata", 32'(ram_if.mem_wdata), 0);

      // Test 1: address pattern, good RAM
      start_test(2'd0);
      check("t1_e0_busy",  32'(busy),             1);
      check("t1_e0_en",    32'(ram_if.mem_en),    1);
      check("t1_e0_wr",    32'(ram_if.mem_wr),    1);
      check("t1_e0_addr",  32'(ram_if.mem_addr),  0);
      check("t1_e0_wdata", 32'(ram_if.mem_wdata), 0);
      tick(3);
      check("t1_e3_addr",  32'(ram_if.mem_addr),  3);
      check("t1_e3_wdata", 32'(ram_if.mem_wdata), 3);
      tick(5);
      check("t1_e8_en",    32'(ram_if.mem_en),    1);
      check("t1_e8_wr",    32'(ram_if.mem_wr),    0);
      check("t1_e8_addr",  32'(ram_if.mem_addr),  0);
      check("t1_e8_wdata", 32'(ram_if.mem_wdata), 0);
      tick(8);
      check("t1_e16_en",   32'(ram_if.mem_en),    0);
      tick(1);
      check("t1_e17_done", 32'(done),             0);
      check("t1_e17_busy", 32'(busy),             1);
      tick(1);
      check("t1_e18_done", 32'(done),             1);
      check("t1_e18_busy", 32'(busy),             0);
      check("t1_e18_pass", 32'(pass),             1);
      check("t1_e18_err",  32'(err_cnt),          0);
      for (int i = 0; i < DEPTH; i++) check("t1_ram_word", 32'(ram_q[i]), 32'(i));
      tick(1);
      check("t1_done_hold", 32'(done),            1);
      check("t1_pass_hold", 32'(pass),            1);

      // Test 2: checkerboard, good RAM
      start_test(2'd1);
      check("t2_e0_wdata", 32'(ram_if.mem_wdata), 32'h AA);
      tick(1);
      check("t2_e1_wdata", 32'(ram_if.mem_wdata), 32'h 55);
      tick(1);
      check("t2_e2_wdata", 32'(ram_if.mem_wdata), 32'h AA);
      tick(16);
      check("t2_done",     32'(done),             1);
      check("t2_pass",     32'(pass),             1);
      check("t2_ram0",     32'(ram_q[0]),         32'h AA);
      check("t2_ram7",     32'(ram_q[7]),         32'h 55);

      // Test 3: single stuck bit at address 5
      fault_mode = 1;
      start_test(2'd0);
      tick(18);
      check("t3_done",      32'(done),      1);
      check("t3_err_cnt",   32'(err_cnt),   1);
      check("t3_fail_addr", 32'(fail_addr), 5);
      check("t3_fail_data", 32'(fail_data), 32'h 04);
      check("t3_pass",      32'(pass),      0);

      // Test 4: whole word stuck at 0, all-ones pattern
      fault_mode = 2;
      start_test(2'd3);
      check("t4_e0_done",   32'(done),             0);
      check("t4_e0_err",    32'(err_cnt),          0);
      check("t4_e0_faddr",  32'(fail_addr),        0);
      check("t4_e0_fdata",  32'(fail_data),        0);
      check("t4_e0_wdata",  32'(ram_if.mem_wdata), 32'h FF);
      tick(18);
      check("t4_done",      32'(done),      1);
      check("t4_err_cnt",   32'(err_cnt),   8);
      check("t4_fail_addr", 32'(fail_addr), 0);
      check("t4_fail_data", 32'(fail_data), 0);
      check("t4_pass",      32'(pass),      0);

      // Test 5: reset during READ, then rst+start together, then a clean run
      fault_mode = 0;
      start_test(2'd2);
      check("t5_e0_wdata", 32'(ram_if.mem_wdata), 32'h FF);
      tick(1);
      check("t5_e1_wdata", 32'(ram_if.mem_wdata), 32'h FE);
      tick(10);
      check("t5_e11_addr", 32'(ram_if.mem_addr),  3);
      check("t5_e11_wr",   32'(ram_if.mem_wr),    0);
      check("t5_e11_en",   32'(ram_if.mem_en),    1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("t5_rst_en",   32'(ram_if.mem_en),    0);
      check("t5_rst_busy", 32'(busy),             0);
      check("t5_rst_done", 32'(done),             0);
      check("t5_rst_err",  32'(err_cnt),          0);
      rst = 1'b1; start = 1'b1;
      tick(1);
      rst = 1'b0; start = 1'b0;
      check("t5_rststart_busy", 32'(busy),          0);
      check("t5_rststart_en",   32'(ram_if.mem_en), 0);
      tick(2);
      check("t5_idle_en",  32'(ram_if.mem_en),    0);
      start_test(2'd2);
      tick(18);
      check("t5_done",     32'(done),             1);
      check("t5_pass",     32'(pass),             1);
      check("t5_ram3",     32'(ram_q[3]),         32'h FC);

      // Test 6: start pulse mid-test ignored; start held across FIN restarts
      start_test(2'd0);
      tick(3);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      check("t6_pulse_addr",  32'(ram_if.mem_addr),  4);
      check("t6_pulse_wdata", 32'(ram_if.mem_wdata), 4);
      check("t6_pulse_wr",    32'(ram_if.mem_wr),    1);
      check("t6_pulse_busy",  32'(busy),             1);
      tick(6);
      start = 1'b1;
      tick(8);
      check("t6_fin_done",    32'(done),             1);
      check("t6_fin_busy",    32'(busy),             0);
      check("t6_fin_en",      32'(ram_if.mem_en),    0);
      tick(1);
      start = 1'b0;
      check("t6_re_done",     32'(done),             0);
      check("t6_re_busy",     32'(busy),             1);
      check("t6_re_en",       32'(ram_if.mem_en),    1);
      check("t6_re_wr",       32'(ram_if.mem_wr),    1);
      check("t6_re_addr",     32'(ram_if.mem_addr),  0);
      tick(18);
      check("t6_done",        32'(done),             1);
      check("t6_pass",        32'(pass),             1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
